// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Line address is byte address bits [31:4]; one line is 128 bits.
package mem_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Line-handshake bundle: I-side and D-side requesters plus the shared memory port.
// slave = arbiter view, master = environment (caches + memory) view.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic  i_read;
  logic  i_write;
  addr_t i_addr;
  line_t i_wdata;
  line_t i_rdata;
  logic  i_ready;

  logic  d_read;
  logic  d_write;
  addr_t d_addr;
  line_t d_wdata;
  line_t d_rdata;
  logic  d_ready;

  logic  mem_read;
  logic  mem_write;
  addr_t mem_addr;
  line_t mem_wdata;
  line_t mem_rdata;
  logic  mem_ready;

  modport slave (
    input  i_read, i_write, i_addr, i_wdata,
    output i_rdata, i_ready,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output i_read, i_write, i_addr, i_wdata,
    input  i_rdata, i_ready,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; on contention the side that
// did not win last time is chosen.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_e last_grant,
  output logic   gnt_d,
  output logic   gnt_valid
);

  assign gnt_valid = req_i | req_d;
  assign gnt_d     = req_d & (~req_i | (last_grant == GRANT_I));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slow_memory line port between I-side and D-side L2.
// Request reaches memory one cycle after it is raised; x_ready pulses one cycle after mem_ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          proc_reset,
  mem_arbiter_if.slave  bus,
  output logic          grant_d,
  output logic          timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  grant_e           last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             grant_d_q, grant_d_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  addr_t            mem_addr_q, mem_addr_d;
  line_t            mem_wdata_q, mem_wdata_d;
  line_t            i_rdata_q, i_rdata_d;
  line_t            d_rdata_q, d_rdata_d;
  logic             i_ready_q, i_ready_d;
  logic             d_ready_q, d_ready_d;

  logic req_i, req_d, pick_d, pick_vld;

  assign req_i = bus.i_read | bus.i_write;
  assign req_d = bus.d_read | bus.d_write;

  rr_arb2 u_rr_arb2 (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant_q),
    .gnt_d      (pick_d),
    .gnt_valid  (pick_vld)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    grant_d_d     = grant_d_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    i_ready_d     = 1'b0;
    d_ready_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d_d    = pick_d;
          last_grant_d = pick_d ? GRANT_D : GRANT_I;
          cnt_d        = '0;
          state_d      = BUSY;
          // Write takes priority when a side raises read and write together.
          if (pick_d) begin
            mem_write_d = bus.d_write;
            mem_read_d  = bus.d_read & ~bus.d_write;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            mem_write_d = bus.i_write;
            mem_read_d  = bus.i_read & ~bus.i_write;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = bus.i_wdata;
          end
        end
      end

      BUSY: begin
        if (bus.mem_ready) begin
          if (grant_d_q) begin
            d_rdata_d = bus.mem_rdata;
            d_ready_d = 1'b1;
          end else begin
            i_rdata_d = bus.mem_rdata;
            i_ready_d = 1'b1;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          grant_d_d   = 1'b0;
          cnt_d       = '0;
          state_d     = RELEASE;
        end else begin
          // Watchdog only flags; the transaction keeps waiting for memory.
          if (cnt_q != TIMEOUT_C) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (cnt_d == TIMEOUT_C) begin
            timeout_err_d = 1'b1;
          end
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_I;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      grant_d_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_ready_q     <= 1'b0;
      d_ready_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      grant_d_q     <= grant_d_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      i_ready_q     <= i_ready_d;
      d_ready_q     <= d_ready_d;
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign grant_d       = grant_d_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, contention, alternation,
// read+write collision, spurious mem_ready and the non-aborting watchdog.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic proc_reset;
  logic grant_d;
  logic timeout_err;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .bus         (bus),
    .grant_d     (grant_d),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  line_t exp_i_rdata;
  line_t exp_d_rdata;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    step(1);
    chk("rst mem_read",    bus.mem_read,    '0);
    chk("rst mem_write",   bus.mem_write,   '0);
    chk("rst mem_addr",    bus.mem_addr,    '0);
    chk("rst mem_wdata",   bus.mem_wdata,   '0);
    chk("rst i_ready",     bus.i_ready,     '0);
    chk("rst d_ready",     bus.d_ready,     '0);
    chk("rst i_rdata",     bus.i_rdata,     '0);
    chk("rst d_rdata",     bus.d_rdata,     '0);
    chk("rst grant_d",     grant_d,         '0);
    chk("rst timeout_err", timeout_err,     '0);
    proc_reset  = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
  endtask

  // Called in the cycle the request is visible with the arbiter idle; returns
  // in the first IDLE cycle after RELEASE with the granted side's request dropped.
  task automatic do_txn(input bit side_d, input bit is_wr, input addr_t addr,
                        input line_t wdata, input line_t rdata, input int k);
    step(1);
    chk("txn grant_d",   grant_d,       side_d);
    chk("txn mem_read",  bus.mem_read,  !is_wr);
    chk("txn mem_write", bus.mem_write, is_wr);
    chk("txn mem_addr",  bus.mem_addr,  addr);
    if (is_wr) chk("txn mem_wdata", bus.mem_wdata, wdata);
    step(k - 1);
    chk("txn hold addr",  bus.mem_addr, addr);
    chk("txn early i_ready", bus.i_ready, '0);
    chk("txn early d_ready", bus.d_ready, '0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rdata;
    step(1);
    bus.mem_ready = 1'b0;
    if (side_d) exp_d_rdata = rdata;
    else        exp_i_rdata = rdata;
    chk("done i_ready",   bus.i_ready,   !side_d);
    chk("done d_ready",   bus.d_ready,   side_d);
    chk("done i_rdata",   bus.i_rdata,   exp_i_rdata);
    chk("done d_rdata",   bus.d_rdata,   exp_d_rdata);
    chk("done mem_read",  bus.mem_read,  '0);
    chk("done mem_write", bus.mem_write, '0);
    chk("done grant_d",   grant_d,       '0);
    if (side_d) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end else begin
      bus.i_read  = 1'b0;
      bus.i_write = 1'b0;
    end
    step(1);
    chk("rel i_ready",   bus.i_ready,   '0);
    chk("rel d_ready",   bus.d_ready,   '0);
    chk("rel mem_read",  bus.mem_read,  '0);
    chk("rel mem_write", bus.mem_write, '0);
  endtask

  initial begin
    proc_reset    = 1'b1;
    bus.i_read    = 1'b0;
    bus.i_write   = 1'b0;
    bus.i_addr    = '0;
    bus.i_wdata   = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    exp_i_rdata   = '0;
    exp_d_rdata   = '0;

    // Single I read, memory ready in cycle 10, i_ready in cycle 11.
    do_reset();
    bus.i_read = 1'b1;
    bus.i_addr = 28'h0000010;
    chk("t1 cycle0 mem_read", bus.mem_read, '0);
    do_txn(1'b0, 1'b0, 28'h0000010, '0, {4{32'hA5A5A5A5}}, 10);

    // Spurious mem_ready while idle.
    bus.mem_ready = 1'b1;
    bus.mem_rdata = {4{32'hFFFF_FFFF}};
    step(2);
    chk("spur i_ready",   bus.i_ready,   '0);
    chk("spur d_ready",   bus.d_ready,   '0);
    chk("spur mem_read",  bus.mem_read,  '0);
    chk("spur mem_write", bus.mem_write, '0);
    chk("spur i_rdata",   bus.i_rdata,   exp_i_rdata);
    chk("spur d_rdata",   bus.d_rdata,   exp_d_rdata);
    chk("spur grant_d",   grant_d,       '0);
    bus.mem_ready = 1'b0;
    bus.i_read    = 1'b1;
    bus.i_addr    = 28'h0000020;
    do_txn(1'b0, 1'b0, 28'h0000020, '0, {4{32'h1234_5678}}, 2);

    // D write and I read together after reset: D first, then I.
    do_reset();
    bus.d_write = 1'b1;
    bus.d_addr  = 28'h0000020;
    bus.d_wdata = {4{32'hDEAD_BEEF}};
    bus.i_read  = 1'b1;
    bus.i_addr  = 28'h0000030;
    do_txn(1'b1, 1'b1, 28'h0000020, {4{32'hDEAD_BEEF}}, {4{32'h0BAD_F00D}}, 3);
    do_txn(1'b0, 1'b0, 28'h0000030, '0, {4{32'h5A5A_5A5A}}, 4);

    // Continuous requests from both sides alternate D, I, D, I ...
    do_reset();
    bus.i_addr = 28'h0001000;
    bus.d_addr = 28'h0002000;
    for (int j = 0; j < 8; j++) begin
      bus.i_read = 1'b1;
      bus.d_read = 1'b1;
      do_txn((j % 2) == 0, 1'b0, ((j % 2) == 0) ? 28'h0002000 : 28'h0001000,
             '0, line_t'(32'hC0DE_0000 + j), 2 + (j % 3));
    end
    bus.d_read = 1'b0;

    // Read and write together on D: write wins.
    bus.d_read  = 1'b1;
    bus.d_write = 1'b1;
    bus.d_addr  = 28'h0000100;
    bus.d_wdata = {4{32'hCAFE_F00D}};
    do_txn(1'b1, 1'b1, 28'h0000100, {4{32'hCAFE_F00D}}, {4{32'h7777_7777}}, 2);

    // Memory never answers: watchdog sets after 16 BUSY cycles, reset abandons.
    bus.i_read = 1'b1;
    bus.i_addr = 28'h0000040;
    step(1);
    chk("wd mem_read start", bus.mem_read, 1'b1);
    step(15);
    chk("wd err before", timeout_err, '0);
    step(1);
    chk("wd err set", timeout_err, 1'b1);
    step(5);
    chk("wd err sticky", timeout_err, 1'b1);
    chk("wd mem_read held", bus.mem_read, 1'b1);
    chk("wd mem_addr held", bus.mem_addr, 28'h0000040);
    chk("wd no i_ready", bus.i_ready, '0);
    proc_reset = 1'b1;
    step(1);
    chk("wd rst mem_read", bus.mem_read, '0);
    chk("wd rst i_ready",  bus.i_ready,  '0);
    chk("wd rst err",      timeout_err,  '0);
    bus.i_read = 1'b0;
    proc_reset = 1'b0;
    step(2);
    chk("wd post i_ready",  bus.i_ready,  '0);
    chk("wd post mem_read", bus.mem_read, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
